// File: rtl/alu_exec.sv
// Execute stage behind the ALU operand/opcode selector: single-cycle add/logic ops,
// bit-serial shifts/rotates, registered result and architectural carry/overflow flags.
package alu_exec_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_LSL = 4'h5;
  localparam logic [3:0] OP_LSR = 4'h6;
  localparam logic [3:0] OP_CSL = 4'h7;
  localparam logic [3:0] OP_CSR = 4'h8;
  localparam logic [3:0] OP_ASR = 4'h9;
endpackage

module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int WORD_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(WORD_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] alu_a,
  input  logic [WORD_WIDTH-1:0] alu_b,
  input  logic                  alu_ic,
  input  logic [3:0]            alu_opcode,
  input  logic                  store_carry,
  input  logic                  store_overflow,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  overflow,
  output logic                  busy
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  // Returns {carry_new, overflow_new, result} for ops that finish at the accept edge.
  function automatic logic [WORD_WIDTH+1:0] f_single(input logic [3:0] op,
                                                     input logic [WORD_WIDTH-1:0] a,
                                                     input logic [WORD_WIDTH-1:0] b,
                                                     input logic ic);
    logic [WORD_WIDTH:0] sum;
    logic                ovf;
    sum = {1'b0, a} + {1'b0, b} + {{WORD_WIDTH{1'b0}}, ic};
    ovf = (a[WORD_WIDTH-1] == b[WORD_WIDTH-1]) && (sum[WORD_WIDTH-1] != a[WORD_WIDTH-1]);
    case (op)
      OP_ADD:  f_single = {sum[WORD_WIDTH], ovf, sum[WORD_WIDTH-1:0]};
      OP_AND:  f_single = {2'b00, a & b};
      OP_OR:   f_single = {2'b00, a | b};
      OP_XOR:  f_single = {2'b00, a ^ b};
      default: f_single = {2'b00, b};
    endcase
  endfunction

  function automatic logic f_is_shift(input logic [3:0] op);
    case (op)
      OP_LSL, OP_LSR, OP_CSL, OP_CSR, OP_ASR: f_is_shift = 1'b1;
      default:                                f_is_shift = 1'b0;
    endcase
  endfunction

  function automatic logic [WORD_WIDTH-1:0] f_shift1(input logic [3:0] op,
                                                     input logic [WORD_WIDTH-1:0] v);
    case (op)
      OP_LSL:  f_shift1 = {v[WORD_WIDTH-2:0], 1'b0};
      OP_LSR:  f_shift1 = {1'b0, v[WORD_WIDTH-1:1]};
      OP_ASR:  f_shift1 = {v[WORD_WIDTH-1], v[WORD_WIDTH-1:1]};
      OP_CSL:  f_shift1 = {v[WORD_WIDTH-2:0], v[WORD_WIDTH-1]};
      OP_CSR:  f_shift1 = {v[0], v[WORD_WIDTH-1:1]};
      default: f_shift1 = v;
    endcase
  endfunction

  state_t                 r_state, w_state_nxt;
  logic [WORD_WIDTH-1:0]  r_work, w_work_nxt;
  logic [SHAMT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]             r_op, w_op_nxt;
  logic                   r_st_c, w_st_c_nxt;
  logic                   r_st_v, w_st_v_nxt;
  logic [WORD_WIDTH-1:0]  r_result, w_result_nxt;
  logic                   r_out_valid, w_out_valid_nxt;
  logic                   r_carry, w_carry_nxt;
  logic                   r_overflow, w_overflow_nxt;

  logic                   w_accept;
  logic [SHAMT_WIDTH-1:0] w_shamt;
  logic [WORD_WIDTH+1:0]  w_single;
  logic [WORD_WIDTH-1:0]  w_shifted;

  assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_shamt   = alu_a[SHAMT_WIDTH-1:0];
  assign w_single  = f_single(alu_opcode, alu_a, alu_b, alu_ic);
  assign w_shifted = f_shift1(r_op, r_work);

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign busy      = (r_state == S_SHIFT);

  // Next-state and datapath update for accept, shift iteration and result consumption.
  always_comb begin
    w_state_nxt     = r_state;
    w_work_nxt      = r_work;
    w_cnt_nxt       = r_cnt;
    w_op_nxt        = r_op;
    w_st_c_nxt      = r_st_c;
    w_st_v_nxt      = r_st_v;
    w_result_nxt    = r_result;
    w_out_valid_nxt = r_out_valid && !out_ready;
    w_carry_nxt     = r_carry;
    w_overflow_nxt  = r_overflow;
    case (r_state)
      S_IDLE: begin
        if (w_accept && f_is_shift(alu_opcode) && (w_shamt != '0)) begin
          w_work_nxt  = alu_b;
          w_cnt_nxt   = w_shamt;
          w_op_nxt    = alu_opcode;
          w_st_c_nxt  = store_carry;
          w_st_v_nxt  = store_overflow;
          w_state_nxt = S_SHIFT;
        end else if (w_accept) begin
          w_result_nxt    = w_single[WORD_WIDTH-1:0];
          w_out_valid_nxt = 1'b1;
          w_carry_nxt     = store_carry    ? w_single[WORD_WIDTH+1] : r_carry;
          w_overflow_nxt  = store_overflow ? w_single[WORD_WIDTH]   : r_overflow;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        w_work_nxt = w_shifted;
        w_cnt_nxt  = r_cnt - SHAMT_WIDTH'(1);
        // Output register is guaranteed free here: accept required it and nothing else enters.
        if (r_cnt == SHAMT_WIDTH'(1)) begin
          w_result_nxt    = w_shifted;
          w_out_valid_nxt = 1'b1;
          w_carry_nxt     = r_st_c ? 1'b0 : r_carry;
          w_overflow_nxt  = r_st_v ? 1'b0 : r_overflow;
          w_state_nxt     = S_IDLE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_op        <= 4'h0;
      r_st_c      <= 1'b0;
      r_st_v      <= 1'b0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_work      <= w_work_nxt;
      r_cnt       <= w_cnt_nxt;
      r_op        <= w_op_nxt;
      r_st_c      <= w_st_c_nxt;
      r_st_v      <= w_st_v_nxt;
      r_result    <= w_result_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_carry     <= w_carry_nxt;
      r_overflow  <= w_overflow_nxt;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec: reset, add flags, shifts, backpressure, streaming.
module tb_alu_exec;
  import alu_exec_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_ic;
  logic [3:0]  alu_opcode;
  logic        store_carry;
  logic        store_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry;
  logic        overflow;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  alu_exec #(.WORD_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ic(alu_ic), .alu_opcode(alu_opcode),
    .store_carry(store_carry), .store_overflow(store_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operation for exactly one edge; returns 1 time unit after that edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic ic, input logic sc, input logic sv);
    alu_opcode = op; alu_a = a; alu_b = b; alu_ic = ic;
    store_carry = sc; store_overflow = sv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if ({carry, overflow, busy} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {carry, overflow, busy}); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1);
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL add1_result got=%h exp=0", result); end
    checks++; if ({out_valid, carry, overflow} !== 3'b110) begin failures++; $display("FAIL add1_vco got=%b exp=110", {out_valid, carry, overflow}); end
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1);
    checks++; if (result !== 32'h8000_0000) begin failures++; $display("FAIL add2_result got=%h exp=80000000", result); end
    checks++; if ({carry, overflow} !== 2'b01) begin failures++; $display("FAIL add2_flags got=%b exp=01", {carry, overflow}); end
    // set carry=1 while keeping overflow=1, then add without store enables
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0);
    issue(OP_ADD, 32'h5, 32'h7, 1'b1, 1'b0, 1'b0);
    checks++; if (result !== 32'd13) begin failures++; $display("FAIL add_ic_result got=%0d exp=13", result); end
    checks++; if ({carry, overflow} !== 2'b11) begin failures++; $display("FAIL add_nostore_flags got=%b exp=11", {carry, overflow}); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_consumed got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid_shift();
    logic seen;
    issue(OP_LSL, 32'd20, 32'h1, 1'b0, 1'b1, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    checks++; if ({busy, out_valid} !== 2'b10) begin failures++; $display("FAIL midshift_busy got=%b exp=10", {busy, out_valid}); end
    reset_n = 1'b0;
    #1;
    checks++; if ({out_valid, carry, overflow, busy} !== 4'b0000) begin failures++; $display("FAIL midshift_reset_state got=%b exp=0000", {out_valid, carry, overflow, busy}); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midshift_reset_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midshift_no_result got=%b exp=0", seen); end
  endtask

  task automatic test_shift();
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    issue(OP_ASR, 32'h4, 32'h8000_0001, 1'b0, 1'b1, 1'b0);
    checks++; if (carry !== 1'b1) begin failures++; $display("FAIL asr_carry_held got=%b exp=1", carry); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if ({busy, in_ready, out_valid} !== 3'b100) begin failures++; $display("FAIL asr_busy_c%0d got=%b exp=100", k, {busy, in_ready, out_valid}); end
      @(posedge clk); #1;
    end
    checks++; if ({out_valid, busy} !== 2'b10) begin failures++; $display("FAIL asr_done got=%b exp=10", {out_valid, busy}); end
    checks++; if (result !== 32'hF800_0000) begin failures++; $display("FAIL asr_result got=%h exp=f8000000", result); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL asr_carry got=%b exp=0", carry); end
    issue(OP_CSL, 32'h0000_0021, 32'h8000_0001, 1'b0, 1'b0, 1'b0);
    checks++; if ({busy, out_valid} !== 2'b10) begin failures++; $display("FAIL csl_busy got=%b exp=10", {busy, out_valid}); end
    @(posedge clk); #1;
    checks++; if (result !== 32'h0000_0003 || out_valid !== 1'b1) begin failures++; $display("FAIL csl_result got=%h/%b exp=00000003/1", result, out_valid); end
    issue(OP_LSR, 32'h0, 32'h8000_0001, 1'b0, 1'b0, 1'b0);
    checks++; if (result !== 32'h8000_0001 || out_valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL lsr0_result got=%h/%b/%b exp=80000001/1/0", result, out_valid, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 1'b0, 1'b0);
    alu_opcode = OP_XOR; alu_a = 32'hFF; alu_b = 32'h0F; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++; if (result !== 32'h0000_F000 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold got=%h/%b exp=0000f000/1", result, out_valid); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (result !== 32'h0000_00F0 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_swap got=%h/%b exp=000000f0/1", result, out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    logic [31:0] exp [4];
    ops[0] = OP_AND; as[0] = 32'h0F0F_0F0F; bs[0] = 32'h00FF_00FF; exp[0] = 32'h000F_000F;
    ops[1] = OP_OR;  as[1] = 32'hF000_0000; bs[1] = 32'h0000_000F; exp[1] = 32'hF000_000F;
    ops[2] = OP_NOP; as[2] = 32'h0000_1234; bs[2] = 32'hDEAD_BEEF; exp[2] = 32'hDEAD_BEEF;
    ops[3] = 4'hF;   as[3] = 32'h0000_0001; bs[3] = 32'hCAFE_F00D; exp[3] = 32'hCAFE_F00D;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_opcode = ops[i]; alu_a = as[i]; alu_b = bs[i]; alu_ic = 1'b0;
      store_carry = 1'b0; store_overflow = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (result !== exp[i] || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_result_%0d got=%h/%b exp=%h/1", i, result, out_valid, exp[i]); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_a = 32'h0; alu_b = 32'h0; alu_ic = 1'b0; alu_opcode = OP_NOP;
    store_carry = 1'b0; store_overflow = 1'b0;
    test_reset();
    test_add();
    test_reset_mid_shift();
    test_shift();
    test_backpressure();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
